// File: rtl/mips_step_ctrl.sv
// Instruction-stepping sequencer for the single-cycle MIPS datapath.
// Owns the PC, decodes controls, gates write strobes into COMMIT, picks the next PC.
module mips_step_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      entry_pc,
    input  logic [CNT_W-1:0] max_steps,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [31:0]      pcp4,
    input  logic [31:0]      imm,
    input  logic [25:0]      jtarget,
    output logic [31:0]      pc,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_COMMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;
    // ctrl = {reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op[2:0]}
    logic [8:0]       ctrl_q, ctrl_d;
    logic             beq_q, beq_d;
    logic             jmp_q, jmp_d;

    logic [8:0]       dec_ctrl;
    logic             dec_ok;
    logic             dec_beq;
    logic             dec_jmp;
    logic             unused_inputs;

    assign unused_inputs = ^{ins[25:6], imm[31:30]};

    always_comb begin
        dec_ctrl = '0;
        dec_ok   = 1'b1;
        dec_beq  = 1'b0;
        dec_jmp  = 1'b0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   dec_ctrl = 9'b1_1_0_0_0_0_010;
                    6'h25:   dec_ctrl = 9'b1_1_0_0_0_0_001;
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08:   dec_ctrl = 9'b0_1_1_0_0_0_010;
            6'h23:   dec_ctrl = 9'b0_1_1_1_0_1_010;
            6'h2B:   dec_ctrl = 9'b0_0_1_0_1_0_010;
            6'h04: begin
                dec_ctrl = 9'b0_0_0_0_0_0_110;
                dec_beq  = 1'b1;
            end
            6'h02:   dec_jmp = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        step_d  = step_q;
        max_d   = max_q;
        done_d  = done_q;
        ill_d   = ill_q;
        ctrl_d  = ctrl_q;
        beq_d   = beq_q;
        jmp_d   = jmp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d   = entry_pc;
                    step_d = '0;
                    max_d  = max_steps;
                    ill_d  = 1'b0;
                    if (max_steps == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                ctrl_d  = dec_ok ? dec_ctrl : '0;
                beq_d   = dec_beq;
                jmp_d   = dec_jmp;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!dec_ok) begin
                    ill_d   = 1'b1;
                    ctrl_d  = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                ctrl_d  = '0;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                step_d = step_q + CNT_W'(1);
                beq_d  = 1'b0;
                jmp_d  = 1'b0;
                if (beq_q && zero) begin
                    pc_d = pcp4 + {imm[29:0], 2'b00};
                end else if (jmp_q) begin
                    pc_d = {4'b0000, jtarget, 2'b00};
                end else begin
                    pc_d = pcp4;
                end
                if (step_d == max_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            step_q  <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            ctrl_q  <= '0;
            beq_q   <= 1'b0;
            jmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            max_q   <= max_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            ctrl_q  <= ctrl_d;
            beq_q   <= beq_d;
            jmp_q   <= jmp_d;
        end
    end

    // Controls are held from DECODE through COMMIT; write strobes only open in COMMIT.
    assign pc         = pc_q;
    assign reg_dst    = ctrl_q[8];
    assign reg_write  = ctrl_q[7] & (state_q == S_COMMIT);
    assign alu_src    = ctrl_q[6];
    assign mem_read   = ctrl_q[5];
    assign mem_write  = ctrl_q[4] & (state_q == S_COMMIT);
    assign mem2reg    = ctrl_q[3];
    assign alu_op     = ctrl_q[2:0];
    assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_COMMIT) || (state_q == S_NEXT);
    assign done       = done_q;
    assign illegal    = ill_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Bench for mips_step_ctrl: a vector table, hand sequences and random programs
// checked cycle by cycle against an instruction-level reference model.
module tb_mips_step_ctrl;

    localparam int CNT_W = 16;
    localparam logic [8:0] DEC_MASK = 9'b1_0_1_1_0_1_111;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      entry_pc;
    logic [CNT_W-1:0] max_steps;
    logic [31:0]      ins;
    logic             zero;
    logic [31:0]      pcp4;
    logic [31:0]      imm;
    logic [25:0]      jtarget;
    logic [31:0]      pc;
    logic             reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg;
    logic [2:0]       alu_op;
    logic             busy, done, illegal;
    logic [CNT_W-1:0] step_count;

    logic [31:0] mem [0:63];
    logic [8:0]  ctrl_v;
    int          nchk = 0;
    int          nerr = 0;
    int          rw_pulses;
    logic [8:0]  cap_dec, cap_com;
    int          zmode;
    logic        zero_fix;

    mips_step_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .entry_pc(entry_pc),
        .max_steps(max_steps), .ins(ins), .zero(zero), .pcp4(pcp4), .imm(imm),
        .jtarget(jtarget), .pc(pc), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem2reg(mem2reg), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal), .step_count(step_count)
    );

    // Fetch/decode stage stand-ins
    assign ins     = mem[pc[7:2]];
    assign pcp4    = pc + 32'd4;
    assign imm     = {{16{ins[15]}}, ins[15:0]};
    assign jtarget = ins[25:0];
    assign ctrl_v  = {reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controls per opcode/funct; kind: 0 plain, 1 beq, 2 j, 3 unsupported
    function automatic void ref_dec(input logic [31:0] w, output logic [8:0] c, output int kind);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        c = '0;
        kind = 0;
        if (op == 6'h00 && fn == 6'h20)      c = 9'b1_1_0_0_0_0_010;
        else if (op == 6'h00 && fn == 6'h25) c = 9'b1_1_0_0_0_0_001;
        else if (op == 6'h08)                c = 9'b0_1_1_0_0_0_010;
        else if (op == 6'h23)                c = 9'b0_1_1_1_0_1_010;
        else if (op == 6'h2B)                c = 9'b0_0_1_0_1_0_010;
        else if (op == 6'h04) begin c = 9'b0_0_0_0_0_0_110; kind = 1; end
        else if (op == 6'h02)                kind = 2;
        else                                 kind = 3;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k <= 2)       return {6'h00, r[25:6], 6'h20};
        else if (k <= 4)  return {6'h00, r[25:6], 6'h25};
        else if (k <= 6)  return {6'h08, r[25:0]};
        else if (k <= 8)  return {6'h23, r[25:0]};
        else if (k <= 10) return {6'h2B, r[25:0]};
        else if (k <= 12) return {6'h04, r[25:0]};
        else if (k == 13) return {6'h02, r[25:0]};
        else if (k == 14) return {6'h3F, r[25:0]};
        else              return {6'h00, r[25:6], 6'h22};
    endfunction

    task automatic stir(input bit noise);
        zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zero_fix;
        if (noise) begin
            start    = 1'($urandom_range(0, 3) == 0);
            entry_pc = $urandom & 32'hFFFF_FFFC;
        end
    endtask

    // One run from entry, checked every cycle against the instruction-level model
    task automatic run(input logic [31:0] entry, input logic [CNT_W-1:0] maxs, input bit noise);
        logic [31:0] mpc, w, off;
        logic [8:0]  ec;
        int          kind;
        int          steps;
        @(negedge clk);
        start = 1'b1; entry_pc = entry; max_steps = maxs;
        @(negedge clk);
        start = 1'b0;
        mpc = entry; steps = 0; rw_pulses = 0; cap_dec = '0; cap_com = '0;
        if (maxs == '0) begin
            chk("zero_run_status", {busy, done, illegal, step_count}, {3'b010, CNT_W'(0)});
            chk("zero_run_pc", pc, entry);
            return;
        end
        forever begin
            w = mem[mpc[7:2]];
            ref_dec(w, ec, kind);
            chk("fetch_pc", pc, mpc);
            chk("fetch_ctrl", ctrl_v, 9'd0);
            chk("fetch_status", {busy, done, illegal, step_count}, {3'b100, CNT_W'(steps)});
            stir(noise);
            @(negedge clk);
            cap_dec = ctrl_v;
            chk("decode_pc", pc, mpc);
            if (kind == 3) chk("decode_strobes", {reg_write, mem_write}, 2'b00);
            else           chk("decode_ctrl", ctrl_v, ec & DEC_MASK);
            stir(noise);
            @(negedge clk);
            if (kind == 3) begin
                start = 1'b0;
                chk("illegal_status", {busy, done, illegal, step_count}, {3'b001, CNT_W'(steps)});
                chk("illegal_strobes", {reg_write, mem_write}, 2'b00);
                chk("illegal_pc", pc, mpc);
                return;
            end
            cap_com = ctrl_v;
            chk("commit_ctrl", ctrl_v, ec);
            rw_pulses += int'(reg_write);
            stir(noise);
            @(negedge clk);
            chk("next_ctrl", ctrl_v, 9'd0);
            chk("next_pc_hold", pc, mpc);
            stir(noise);
            off = {{14{w[15]}}, w[15:0], 2'b00};
            if (kind == 1 && zero) mpc = mpc + 32'd4 + off;
            else if (kind == 2)    mpc = {4'b0000, w[25:0], 2'b00};
            else                   mpc = mpc + 32'd4;
            steps++;
            @(negedge clk);
            if (steps == int'(maxs)) begin
                start = 1'b0;
                chk("done_status", {busy, done, illegal, step_count}, {3'b010, CNT_W'(steps)});
                chk("done_pc", pc, mpc);
                return;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] entry;
        logic [31:0] word;
        logic        z;
        logic [8:0]  exp_ctrl;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"add",    32'd128, 32'h0085_1820, 1'b0, 9'b1_1_0_0_0_0_010, 32'd132,     1'b0};
        vecs[1] = '{"or",     32'd132, 32'h0085_1825, 1'b0, 9'b1_1_0_0_0_0_001, 32'd136,     1'b0};
        vecs[2] = '{"addi",   32'd136, 32'h2083_0007, 1'b0, 9'b0_1_1_0_0_0_010, 32'd140,     1'b0};
        vecs[3] = '{"lw",     32'd144, 32'h8C83_0010, 1'b0, 9'b0_1_1_1_0_1_010, 32'd148,     1'b0};
        vecs[4] = '{"sw",     32'd144, 32'hAC83_0010, 1'b1, 9'b0_0_1_0_1_0_010, 32'd148,     1'b0};
        vecs[5] = '{"beq_t",  32'd140, 32'h1085_FFFE, 1'b1, 9'b0_0_0_0_0_0_110, 32'd136,     1'b0};
        vecs[6] = '{"beq_nt", 32'd140, 32'h1085_FFFE, 1'b0, 9'b0_0_0_0_0_0_110, 32'd144,     1'b0};
        vecs[7] = '{"j",      32'd160, 32'h0800_0020, 1'b1, 9'b0_0_0_0_0_0_000, 32'h80,      1'b0};
        vecs[8] = '{"ill_op", 32'd140, 32'hFC00_0000, 1'b0, 9'b0_0_0_0_0_0_000, 32'd140,     1'b1};
        vecs[9] = '{"ill_fn", 32'd140, 32'h0085_1822, 1'b0, 9'b0_0_0_0_0_0_000, 32'd140,     1'b1};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0020;
        rst_n = 1'b0; start = 1'b0; entry_pc = '0; max_steps = '0;
        zero = 1'b0; zmode = 0; zero_fix = 1'b0;
        #12;
        chk("reset_pc", pc, 32'd0);
        chk("reset_ctrl", ctrl_v, 9'd0);
        chk("reset_status", {busy, done, illegal, step_count}, {3'b000, CNT_W'(0)});
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the COMMIT cycle of a store
        mem[50] = 32'hAC83_0010;
        @(negedge clk);
        start = 1'b1; entry_pc = 32'd200; max_steps = 16'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sw_commit_write", {mem_write, mem_read}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_write", mem_write, 1'b0);
        chk("midreset_pc", pc, 32'd0);
        chk("midreset_ctrl", ctrl_v, 9'd0);
        chk("midreset_status", {busy, done, illegal, step_count}, {3'b000, CNT_W'(0)});
        @(negedge clk);
        rst_n = 1'b1;
        run(32'd200, 16'd1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            mem[vecs[i].entry[7:2]] = vecs[i].word;
            zmode = 0;
            zero_fix = vecs[i].z;
            run(vecs[i].entry, 16'd1, 1'b0);
            if (!vecs[i].exp_ill) begin
                chk({"vec_dec_", vecs[i].name}, cap_dec, vecs[i].exp_ctrl & DEC_MASK);
                chk({"vec_com_", vecs[i].name}, cap_com, vecs[i].exp_ctrl);
            end
            chk({"vec_pc_", vecs[i].name}, pc, vecs[i].exp_pc);
            chk({"vec_ill_", vecs[i].name}, {illegal, done}, {vecs[i].exp_ill, !vecs[i].exp_ill});
        end

        // Linear program addi/add/or from 128
        mem[32] = 32'h2083_0005;
        mem[33] = 32'h0085_1820;
        mem[34] = 32'h0085_1825;
        zero_fix = 1'b1;
        run(32'd128, 16'd3, 1'b0);
        chk("linear_rw_pulses", rw_pulses, 3);

        // Unsupported word at step 2, then a clean restart
        mem[36] = 32'h2083_0001;
        mem[37] = 32'hFC00_0000;
        run(32'd144, 16'd5, 1'b0);
        chk("ill_step2_count", step_count, 16'd1);
        run(32'd128, 16'd2, 1'b0);
        chk("restart_ill_clear", {illegal, done}, 2'b01);

        run(32'h0000_1230, 16'd0, 1'b0);

        // Random programs with noisy start/zero while busy
        zmode = 2;
        for (int r = 0; r < 25; r++) begin
            logic [31:0] e;
            for (int i = 0; i < 64; i++) mem[i] = rand_ins();
            e = $urandom & 32'hFFFF_FFFC;
            run(e, CNT_W'($urandom_range(1, 12)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mips_step_ctrl.md
# mips_step_ctrl

Hardware sequencer that drives the single-cycle MIPS datapath (fetch, decode, execute, data memory, write-back) in place of a software bench loop. It owns the PC register and decodes each fetched instruction into the datapath control set. It gates the register-file and memory write strobes into a single commit cycle and computes the next PC from the branch, jump and fall-through candidates. It runs a bounded number of instructions from a programmable entry point, then reports done, or reports illegal on an unsupported encoding.

## Interface
Parameters:
- CNT_W, 16, width of step counter and max_steps

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch run; sampled only in IDLE or DONE
- entry_pc  in  32  first instruction address, loaded on accepted start
- max_steps  in  CNT_W  instructions to execute per run
- ins  in  32  instruction word from fetch stage for current pc
- zero  in  1  ALU zero flag
- pcp4  in  32  pc+4 from fetch stage
- imm  in  32  sign-extended immediate from decode stage
- jtarget  in  26  jump target field from decode stage
- pc  out  32  current fetch address
- reg_dst, reg_write, alu_src, mem_read, mem_write, mem2reg  out  1 each  datapath controls
- alu_op  out  3  ALU operation: 010 add, 001 or, 110 sub
- busy  out  1  run in progress
- done  out  1  run completed normally; sticky until next start
- illegal  out  1  halted on unsupported instruction; sticky until next start
- step_count  out  CNT_W  instructions committed in current or last run

## Operation
- States: IDLE, FETCH, DECODE, COMMIT, NEXT, DONE.
- IDLE/DONE, start=1: pc<=entry_pc, step_count<=0, done<=0, illegal<=0.
  - max_steps==0: go directly to DONE with done=1.
  - Otherwise go to FETCH; busy=1.
- FETCH: pc stable for one cycle so ins, pcp4, imm and jtarget settle. Controls are all 0.
- DECODE: register controls from ins[31:26]/ins[5:0]:
  - R-type (00) funct 20h: reg_dst=1, reg_write=1, alu_src=0, alu_op=010.
  - R-type (00) funct 25h: same as funct 20h, but alu_op=001.
  - addi (08): reg_write=1, alu_src=1, alu_op=010.
  - lw (23): reg_write=1, alu_src=1, mem_read=1, mem2reg=1, alu_op=010.
  - sw (2B): alu_src=1, mem_write=1, alu_op=010.
  - beq (04): alu_src=0, alu_op=110.
  - j (02): all controls 0.
  - Any other opcode, or R-type with any other funct: illegal<=1, busy<=0, go to DONE with done=0. No commit occurs.
- COMMIT: the only state in which reg_write and mem_write may be 1. All other controls are held from DECODE through COMMIT.
- NEXT: all controls return to 0, and step_count increments by 1. Next pc is chosen as:
  - beq with zero=1: pcp4 + (imm<<2), modulo 2^32.
  - j: {4'b0, jtarget, 2'b00}.
  - Otherwise: pcp4.
- NEXT exit: if the new step_count equals max_steps, go to DONE with done=1 and busy=0; otherwise go to FETCH.
- start while busy: ignored.
- zero is sampled only in NEXT.

## Timing
- Each instruction takes exactly 4 cycles (FETCH, DECODE, COMMIT, NEXT).
- First FETCH is the cycle after start is accepted.
- done rises at the edge that leaves NEXT on the final step.
- Write strobes last exactly one cycle per committing instruction, so a lw/sw/R/addi produces exactly one write pulse.
- Illegal detection occurs at the DECODE edge. illegal=1 is visible 2 cycles after the offending FETCH starts. step_count excludes the offending instruction.
- Reset values (asynchronous on rst_n=0): state=IDLE, pc=0, all controls 0, alu_op=000, busy=0, done=0, illegal=0, step_count=0.
- Reset mid-run drops write strobes immediately; no partial commit may survive.
- step_count wraps never: a run ends at max_steps ≤ 2^CNT_W−1.

## Test plan
- Reset mid-COMMIT of sw: assert rst_n=0 → mem_write drops same cycle, busy=0, pc=0, state IDLE; deassert rst_n and start → normal run.
- Linear program: entry_pc=128, addi, add, or, max_steps=3. Expected response:
  - pc sequence 128, 132, 136.
  - reg_write pulses exactly 3 times, one cycle each.
  - done=1 after 12 cycles.
  - step_count=3.
- Branch taken vs not taken:
  - beq with imm=−2 at pc=140, zero=1 → next pc=136.
  - Same beq with zero=0 → next pc=144.
  - alu_op=110 during DECODE/COMMIT in both cases.
- Jump: j at pc=160 with jtarget=20h → next pc=80h; no write strobes; step_count+1.
- lw/sw at the same address:
  - sw: mem_write high exactly in COMMIT, mem_read=0.
  - lw: mem_read=1 and mem2reg=1 in DECODE and COMMIT, reg_write only in COMMIT.
- Illegal handling:
  - ins=FC000000h at step 2 → illegal=1, done=0, busy=0, step_count=1, no strobes.
  - Restart with start=1 → illegal clears.
  - max_steps=0 → done on the cycle after start, pc=entry_pc.
